// File: rtl/pp_uart_pkg.sv
// ============================================================================
// Module   : pp_uart_pkg
// Purpose  : Shared state encoding and framing constants for the UART receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pp_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int SCNT_W     = $clog2(OVERSAMPLE);
    localparam int BCNT_W     = $clog2(DATA_BITS);

    localparam logic [SCNT_W-1:0] VOTE_A      = SCNT_W'(7);
    localparam logic [SCNT_W-1:0] VOTE_B      = SCNT_W'(8);
    localparam logic [SCNT_W-1:0] VOTE_C      = SCNT_W'(9);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pp_uart_rx_sampler.sv
// ============================================================================
// Module   : pp_uart_rx_sampler
// Purpose  : rxd synchroniser, falling-edge detect and 3-sample majority vote.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pp_uart_rx_sampler
    import pp_uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              baud_tick,
    input  logic [SCNT_W-1:0] scnt,
    input  logic              rxd,
    output logic              fall,
    output logic              vote
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic                   rxs_d;
    logic                   samp_a;
    logic                   samp_b;

    assign rxs = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '1;
            rxs_d  <= 1'b1;
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else if (!soft_rst) begin
            sync   <= '1;
            rxs_d  <= 1'b1;
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rxd};
            rxs_d <= rxs;
            if (baud_tick && scnt == VOTE_A) samp_a <= rxs;
            if (baud_tick && scnt == VOTE_B) samp_b <= rxs;
        end
    end

    // The third sample is the live value, so the vote is ready on the VOTE_C tick.
    assign fall = rxs_d & ~rxs;
    assign vote = majority3(samp_a, samp_b, rxs);

endmodule

`default_nettype wire

// File: rtl/pp_uart_rx.sv
// ============================================================================
// Module   : pp_uart_rx
// Purpose  : 16x oversampled UART receiver with one-entry holding register.
//            Optional parity selected by PP_UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pp_uart_rx
    import pp_uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_rst,
    input  logic                 baud_tick,
    input  logic                 rxd,
`ifdef PP_UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    rx_state_t            state;
    logic [SCNT_W-1:0]    scnt;
    logic [BCNT_W-1:0]    bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 fall;
    logic                 vote;
    logic                 tick_vote;
    logic                 tick_last;
    logic                 pop;
    logic                 deliver;
    logic                 load;

    pp_uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .baud_tick (baud_tick),
        .scnt      (scnt),
        .rxd       (rxd),
        .fall      (fall),
        .vote      (vote)
    );

    assign tick_vote = baud_tick & (scnt == VOTE_C);
    assign tick_last = baud_tick & (scnt == LAST_SAMPLE);
    assign pop       = rx_valid & rx_ready;
    assign deliver   = (state == STOP) & tick_vote;
    assign load      = deliver & (~rx_valid | pop);
    assign rx_busy   = (state != IDLE);

`ifdef PP_UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else if (!soft_rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE && fall)
                par_bad <= 1'b0;
            else if (state == PARITY && tick_vote && (vote != (^shreg ^ parity_odd)))
                par_bad <= 1'b1;
            parity_err <= (deliver & par_bad) | (parity_err & ~err_clr);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            scnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (!soft_rst) begin
            state       <= IDLE;
            scnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (baud_tick && state != IDLE) scnt <= scnt + 1'b1;

            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        scnt  <= '0;
                    end
                end
                START: begin
                    if (tick_vote && vote) begin
                        state <= IDLE;
                        scnt  <= '0;
                    end else if (tick_last) begin
                        state <= DATA;
                        scnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                DATA: begin
                    if (tick_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (tick_last) begin
                        scnt <= '0;
                        if (bcnt == LAST_BIT) begin
`ifdef PP_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
`ifdef PP_UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_last) begin
                        state <= STOP;
                        scnt  <= '0;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop-bit lets the next start edge resynchronise.
                    if (tick_vote) begin
                        state <= IDLE;
                        scnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    scnt  <= '0;
                end
            endcase

            if (load) rx_data <= shreg;
            rx_valid    <= load | (rx_valid & ~pop);
            frame_err   <= (deliver & ~vote) | (frame_err & ~err_clr);
            overrun_err <= (deliver & rx_valid & ~pop) | (overrun_err & ~err_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pp_uart_rx.sv
// ============================================================================
// Module   : tb_pp_uart_rx
// Purpose  : Self-checking bench for pp_uart_rx against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pp_uart_rx;

`ifdef PP_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS       = PAR_EN ? 11 : 10;
    localparam int FRAME_TICKS = 16 * NBITS - 6;

    logic       clk = 1'b0;
    logic       rst, soft_rst, baud_tick, rxd, rx_ready, err_clr, parity_odd;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun_err, rx_busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_perr, m_oerr;

    pp_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst    (soft_rst),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
`ifdef PP_UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .err_clr     (err_clr),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud tick every 4 clk, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            baud_tick = (div == 0);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic next_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d ^ parity_odd;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        if (!m_valid) begin
            m_data  = d;
            m_valid = 1'b1;
        end else begin
            m_oerr = 1'b1;
        end
        if (!stop_b) m_ferr = 1'b1;
        if (PAR_EN && par_b != good_par(d)) m_perr = 1'b1;
    endfunction

    // Drives one whole frame; ticks are counted from the first tick after the start edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input int cbit, input int cpos,
                              output int busy_fall, output int valid_rise);
        logic bits[$];
        logic b, prev_valid;
        bit   seen_busy;
        int   t;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_EN) bits.push_back(par_b);
        bits.push_back(stop_b);
        busy_fall  = -1;
        valid_rise = -1;
        seen_busy  = 1'b0;
        t = 0;
        next_tick();
        prev_valid = rx_valid;
        foreach (bits[i]) begin
            for (int j = 1; j <= 16; j++) begin
                b = bits[i];
                rxd = (i == cbit && j == cpos) ? ~b : b;
                next_tick();
                t++;
                if (rx_busy) seen_busy = 1'b1;
                else if (seen_busy && busy_fall < 0) busy_fall = t;
                if (rx_valid && !prev_valid && valid_rise < 0) valid_rise = t;
                prev_valid = rx_valid;
            end
        end
    endtask

    task automatic pop();
        if (m_valid) begin
            @(negedge clk) rx_ready = 1'b1;
            @(negedge clk) rx_ready = 1'b0;
            m_valid = 1'b0;
        end
    endtask

    task automatic clear_errs();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        m_oerr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; soft_rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0; parity_odd = 1'b0;
        m_data = '0; m_valid = 0; m_ferr = 0; m_perr = 0; m_oerr = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_active: got data=%h v=%b f=%b p=%b o=%b busy=%b, expected all 0",
                     rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy);
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        vectors++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_release: got data=%h v=%b f=%b p=%b o=%b busy=%b, expected all 0",
                     rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy);
        end
    endtask

    task automatic test_basic();
        int bf, vr;
        send_frame(8'hA5, 1'b1, good_par(8'hA5), -1, 0, bf, vr);
        model_frame(8'hA5, 1'b1, good_par(8'hA5));
        vectors++;
        if (bf !== FRAME_TICKS) begin
            miscompares++;
            $display("FAIL basic_busy_fall: got tick %0d, expected %0d", bf, FRAME_TICKS);
        end
        vectors++;
        if (vr !== FRAME_TICKS) begin
            miscompares++;
            $display("FAIL basic_valid_rise: got tick %0d, expected %0d", vr, FRAME_TICKS);
        end
        vectors++;
        if (rx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_data: got %h, expected a5", rx_data);
        end
        vectors++;
        if ({rx_valid, frame_err, parity_err, overrun_err} !== {m_valid, m_ferr, m_perr, m_oerr}) begin
            miscompares++;
            $display("FAIL basic_flags: got %b, expected %b",
                     {rx_valid, frame_err, parity_err, overrun_err}, {m_valid, m_ferr, m_perr, m_oerr});
        end
    endtask

    task automatic test_overrun();
        int bf, vr;
        pop();
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, 0, bf, vr);
        model_frame(8'h3C, 1'b1, good_par(8'h3C));
        send_frame(8'h81, 1'b1, good_par(8'h81), -1, 0, bf, vr);
        model_frame(8'h81, 1'b1, good_par(8'h81));
        vectors++;
        if (rx_data !== m_data) begin
            miscompares++;
            $display("FAIL overrun_data: got %h, expected %h", rx_data, m_data);
        end
        vectors++;
        if ({rx_valid, overrun_err} !== {m_valid, m_oerr} || m_oerr !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got v=%b o=%b, expected v=%b o=%b", rx_valid, overrun_err, m_valid, m_oerr);
        end
        clear_errs();
        vectors++;
        if ({rx_valid, frame_err, parity_err, overrun_err} !== {m_valid, m_ferr, m_perr, m_oerr}) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b, expected %b",
                     {rx_valid, frame_err, parity_err, overrun_err}, {m_valid, m_ferr, m_perr, m_oerr});
        end
        pop();
    endtask

    task automatic test_false_start();
        int t, fall_t;
        bit seen;
        fall_t = -1;
        seen = 1'b0;
        next_tick();
        for (t = 1; t <= 40; t++) begin
            rxd = (t <= 3) ? 1'b0 : 1'b1;
            next_tick();
            if (rx_busy) seen = 1'b1;
            else if (seen && fall_t < 0) fall_t = t;
        end
        vectors++;
        if (fall_t !== 10) begin
            miscompares++;
            $display("FAIL false_start_return: got tick %0d, expected 10", fall_t);
        end
        vectors++;
        if ({rx_valid, rx_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL false_start_state: got v=%b busy=%b, expected 0 0", rx_valid, rx_busy);
        end
    endtask

    task automatic test_corrupt_sample();
        int bf, vr, cb, cp;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            pop();
            d  = 8'($urandom);
            cb = $urandom_range(1, 8);
            cp = $urandom_range(8, 10);
            send_frame(d, 1'b1, good_par(d), cb, cp, bf, vr);
            model_frame(d, 1'b1, good_par(d));
            vectors++;
            if (rx_data !== m_data || rx_valid !== m_valid) begin
                miscompares++;
                $display("FAIL corrupt_sample: bit %0d pos %0d got %h v=%b, expected %h v=%b",
                         cb, cp, rx_data, rx_valid, m_data, m_valid);
            end
        end
    endtask

    task automatic test_frame_err();
        int bf, vr, busy_seen;
        pop();
        send_frame(8'h55, 1'b0, good_par(8'h55), -1, 0, bf, vr);
        model_frame(8'h55, 1'b0, good_par(8'h55));
        vectors++;
        if ({rx_data, rx_valid, frame_err} !== {m_data, m_valid, m_ferr} || m_ferr !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err: got data=%h v=%b f=%b, expected data=%h v=%b f=%b",
                     rx_data, rx_valid, frame_err, m_data, m_valid, m_ferr);
        end
        busy_seen = 0;
        for (int t = 0; t < 40; t++) begin
            next_tick();
            if (rx_busy) busy_seen++;
        end
        vectors++;
        if (busy_seen !== 0) begin
            miscompares++;
            $display("FAIL held_low_retrigger: got %0d busy ticks, expected 0", busy_seen);
        end
        rxd = 1'b1;
        repeat (20) next_tick();
    endtask

    task automatic test_soft_reset();
        int bf, vr;
        logic [7:0] d;
        d = 8'($urandom);
        next_tick();
        for (int t = 1; t <= 16 * 5 + 5; t++) begin
            rxd = (t <= 16) ? 1'b0 : d[(t - 17) / 16];
            next_tick();
        end
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL soft_reset_busy_before: got %b, expected 1", rx_busy);
        end
        rxd = 1'b1;
        @(negedge clk) soft_rst = 1'b0;
        @(negedge clk);
        m_data = '0; m_valid = 0; m_ferr = 0; m_perr = 0; m_oerr = 0;
        vectors++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy} !== 13'b0) begin
            miscompares++;
            $display("FAIL soft_reset_outputs: got data=%h v=%b f=%b p=%b o=%b busy=%b, expected all 0",
                     rx_data, rx_valid, frame_err, parity_err, overrun_err, rx_busy);
        end
        soft_rst = 1'b1;
        repeat (20) next_tick();
        send_frame(8'hF0, 1'b1, good_par(8'hF0), -1, 0, bf, vr);
        model_frame(8'hF0, 1'b1, good_par(8'hF0));
        vectors++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun_err} !== {m_data, m_valid, m_ferr, m_perr, m_oerr}) begin
            miscompares++;
            $display("FAIL soft_reset_next_frame: got data=%h flags=%b, expected data=%h flags=%b",
                     rx_data, {rx_valid, frame_err, parity_err, overrun_err},
                     m_data, {m_valid, m_ferr, m_perr, m_oerr});
        end
    endtask

    task automatic test_parity();
        int bf, vr;
        logic [7:0] d;
        logic pb;
        pop();
        clear_errs();
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, -1, 0, bf, vr);
        model_frame(8'h07, 1'b1, 1'b0);
        vectors++;
        if (parity_err !== m_perr || m_perr !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_bad_even: got %b, expected %b", parity_err, m_perr);
        end
        pop();
        clear_errs();
        send_frame(8'h07, 1'b1, 1'b1, -1, 0, bf, vr);
        model_frame(8'h07, 1'b1, 1'b1);
        vectors++;
        if ({rx_data, parity_err} !== {m_data, m_perr}) begin
            miscompares++;
            $display("FAIL parity_good_even: got data=%h p=%b, expected data=%h p=%b", rx_data, parity_err, m_data, m_perr);
        end
        pop();
        parity_odd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d  = 8'($urandom);
            pb = (k == 1) ? ~good_par(d) : good_par(d);
            send_frame(d, 1'b1, pb, -1, 0, bf, vr);
            model_frame(d, 1'b1, pb);
            vectors++;
            if ({rx_data, parity_err} !== {m_data, m_perr}) begin
                miscompares++;
                $display("FAIL parity_odd_%0d: got data=%h p=%b, expected data=%h p=%b",
                         k, rx_data, parity_err, m_data, m_perr);
            end
            pop();
        end
    endtask

    task automatic test_random();
        int bf, vr, cb, cp;
        logic [7:0] d;
        logic sb, pb;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) pop();
            if ($urandom_range(0, 3) == 0) clear_errs();
            if (PAR_EN) parity_odd = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            cb = $urandom_range(0, NBITS - 1);
            cp = $urandom_range(8, 10);
            send_frame(d, sb, pb, cb, cp, bf, vr);
            model_frame(d, sb, pb);
            vectors++;
            if (bf !== FRAME_TICKS) begin
                miscompares++;
                $display("FAIL random_%0d_timing: got tick %0d, expected %0d", k, bf, FRAME_TICKS);
            end
            vectors++;
            if ({rx_data, rx_valid, frame_err, parity_err, overrun_err} !== {m_data, m_valid, m_ferr, m_perr, m_oerr}) begin
                miscompares++;
                $display("FAIL random_%0d: got data=%h flags=%b, expected data=%h flags=%b", k,
                         rx_data, {rx_valid, frame_err, parity_err, overrun_err},
                         m_data, {m_valid, m_ferr, m_perr, m_oerr});
            end
            if (!sb) begin
                rxd = 1'b1;
                repeat (4) next_tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_false_start();
        test_corrupt_sample();
        test_frame_err();
        test_soft_reset();
        if (PAR_EN) test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
